systolic_feeder: RTL and testbench

- Transmit side of the systolic array's left/top data interface: drives the skewed `left_in`/`top_in` wavefronts and the `set_reg` accumulate strobe into an ARRAY_SIZE x ARRAY_SIZE output-stationary PE grid.
- Accepts one A-column/B-row vector pair per beat over a valid/ready handshake and applies per-lane diagonal skew (lane i delayed i cycles).
- Holds `set_reg` until the last operand pair has propagated to the far-corner PE, then pulses `done`.
- Sits between the operand buffers and the PE array top level.

---
 rtl/systolic_pkg.sv | 24 ++
 rtl/skew_delay_line.sv | 27 ++
 rtl/systolic_feeder.sv | 117 +++++++++++
 tb/tb_systolic_feeder.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic array feeder: FSM state encoding,
// flush length and lane slicing.
package systolic_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FEED  = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } state_e;

   // Cycles for the last operand pair to reach PE(N-1,N-1) after it leaves the feeder.
   function automatic int flush_cycles(input int array_size);
      return 2 * (array_size - 1) + 1;
   endfunction

   function automatic int lane_lsb(input int lane, input int data_width);
      return lane * data_width;
   endfunction

   localparam int DEFAULT_ARRAY_SIZE = 4;
   localparam int FLUSH_CYCLES       = flush_cycles(DEFAULT_ARRAY_SIZE);

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-depth shift register used to delay one operand lane by DEPTH cycles.
module skew_delay_line #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] din_i,
   output logic [DATA_WIDTH-1:0] dout_o
);

   logic [DATA_WIDTH-1:0] stage_q [DEPTH];

   // NOTE: every stage is reset, so an aborted job leaves no stale operands in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < DEPTH; k++) stage_q[k] <= '0;
      end else begin
         // NOTE: non-blocking assignments make each stage take its neighbour's old value.
         stage_q[0] <= din_i;
         for (int k = 1; k < DEPTH; k++) stage_q[k] <= stage_q[k-1];
      end
   end

   assign dout_o = stage_q[DEPTH-1];

endmodule

// File: rtl/systolic_feeder.sv
// Transmit side of the PE grid interface: accepts A-column/B-row beats, skews
// lane i by i cycles and holds set_reg until the far-corner PE has its last pair.
module systolic_feeder
   import systolic_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ARRAY_SIZE = 4,
   parameter int K_MAX      = 16
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             start,
   input  logic [$clog2(K_MAX+1)-1:0]       k_len,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] a_vec,
   input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] b_vec,
   output logic [ARRAY_SIZE*DATA_WIDTH-1:0] left_out,
   output logic [ARRAY_SIZE*DATA_WIDTH-1:0] top_out,
   output logic                             set_reg,
   output logic                             busy,
   output logic                             done
);

   localparam int KW      = $clog2(K_MAX+1);
   localparam int FW      = $clog2(2*ARRAY_SIZE);
   localparam int FLUSH_N = flush_cycles(ARRAY_SIZE);

   state_e          state_q, state_d;
   logic [KW-1:0]   k_len_q, k_len_d;
   logic [KW-1:0]   beat_q, beat_d;
   logic [FW-1:0]   flush_q, flush_d;
   logic            set_reg_q, set_reg_d;
   logic            accept;

   assign accept = (state_q == FEED) && in_valid;

   always_comb begin
      // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
      state_d = state_q;
      k_len_d = k_len_q;
      beat_d  = beat_q;
      flush_d = flush_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               if (k_len != '0) begin
                  k_len_d = k_len;
                  beat_d  = '0;
                  state_d = FEED;
               end else begin
                  state_d = DONE;
               end
            end
         end
         FEED: begin
            if (accept) begin
               beat_d = beat_q + 1'b1;
               if (KW'(beat_q + 1'b1) == k_len_q) begin
                  flush_d = '0;
                  state_d = FLUSH;
               end
            end
         end
         FLUSH: begin
            if (flush_q == FW'(FLUSH_N - 1)) state_d = DONE;
            else                             flush_d = flush_q + 1'b1;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // Held across bubbles; drops only once the flush window has fully elapsed.
      set_reg_d = accept || (set_reg_q && (state_d == FEED || state_d == FLUSH));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         k_len_q   <= '0;
         beat_q    <= '0;
         flush_q   <= '0;
         set_reg_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         k_len_q   <= k_len_d;
         beat_q    <= beat_d;
         flush_q   <= flush_d;
         set_reg_q <= set_reg_d;
      end
   end

   assign in_ready = (state_q == FEED);
   assign busy     = (state_q == FEED) || (state_q == FLUSH);
   assign done     = (state_q == DONE);
   assign set_reg  = set_reg_q;

   for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_lane
      logic [DATA_WIDTH-1:0] a_in, b_in;
      assign a_in = accept ? a_vec[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH] : '0;
      assign b_in = accept ? b_vec[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH] : '0;

      skew_delay_line #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(i + 1)) u_skew_a (
         .clk    (clk),
         .rst    (rst),
         .din_i  (a_in),
         .dout_o (left_out[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH])
      );

      skew_delay_line #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(i + 1)) u_skew_b (
         .clk    (clk),
         .rst    (rst),
         .din_i  (b_in),
         .dout_o (top_out[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH])
      );
   end

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder: skew timing, set_reg window, bubbles,
// zero-length jobs, reset abort and an end-to-end run through a 4x4 PE grid model.
module tb_systolic_feeder;

   localparam int DW = 8;
   localparam int N  = 4;
   localparam int KW = $clog2(16 + 1);

   logic            clk = 1'b0;
   logic            rst;
   logic            start;
   logic [KW-1:0]   k_len;
   logic            in_valid;
   logic            in_ready;
   logic [N*DW-1:0] a_vec, b_vec;
   logic [N*DW-1:0] left_out, top_out;
   logic            set_reg, busy, done;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   systolic_feeder #(.DATA_WIDTH(DW), .ARRAY_SIZE(N), .K_MAX(16)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .k_len    (k_len),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .a_vec    (a_vec),
      .b_vec    (b_vec),
      .left_out (left_out),
      .top_out  (top_out),
      .set_reg  (set_reg),
      .busy     (busy),
      .done     (done)
   );

   // Output-stationary PE grid model: forward left/top one hop per cycle, accumulate on set_reg.
   logic        pe_clr;
   logic [DW-1:0] lq [N][N];
   logic [DW-1:0] tq [N][N];
   logic [DW-1:0] lin [N][N];
   logic [DW-1:0] tin [N][N];
   logic [31:0]   acc [N][N];

   always_comb begin
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            lin[i][j] = (j == 0) ? left_out[i*DW +: DW] : lq[i][j-1];
            tin[i][j] = (i == 0) ? top_out[j*DW +: DW]  : tq[i-1][j];
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            lq[i][j] <= lin[i][j];
            tq[i][j] <= tin[i][j];
            if (pe_clr)       acc[i][j] <= '0;
            else if (set_reg) acc[i][j] <= acc[i][j] + 32'(lin[i][j]) * 32'(tin[i][j]);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Caller sits at cycle L+1 (L = last accept); walks through the flush and the done pulse.
   task automatic tail(input string tag);
      for (int rel = 1; rel <= 8; rel++) begin
         check({tag, "_set_reg"}, 64'(set_reg), 64'(rel <= 7));
         check({tag, "_busy"},    64'(busy),    64'(rel <= 7));
         check({tag, "_done"},    64'(done),    64'(rel == 8));
         tick();
      end
      check({tag, "_done_clear"}, 64'(done), 64'd0);
   endtask

   logic [31:0] exp_left [5];
   logic [31:0] exp_top  [5];

   initial begin
      rst = 1'b1; start = 1'b0; k_len = '0; in_valid = 1'b0;
      a_vec = '0; b_vec = '0; pe_clr = 1'b1;
      exp_left = '{32'h0000_0001, 32'h0000_0200, 32'h0003_0000, 32'h0400_0000, 32'h0};
      exp_top  = '{32'h0000_0005, 32'h0000_0600, 32'h0007_0000, 32'h0800_0000, 32'h0};

      tick(); tick();
      check("rst_left",     64'(left_out), 64'd0);
      check("rst_top",      64'(top_out),  64'd0);
      check("rst_set_reg",  64'(set_reg),  64'd0);
      check("rst_busy",     64'(busy),     64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd0);
      check("rst_done",     64'(done),     64'd0);
      rst = 1'b0;
      tick();

      // Reset during beat 2 aborts the job without a done pulse.
      start = 1'b1; k_len = 5'd4;
      tick();
      start = 1'b0;
      check("abort_in_ready", 64'(in_ready), 64'd1);
      in_valid = 1'b1; a_vec = 32'h0A0B_0C0D; b_vec = 32'h1A1B_1C1D;
      tick();
      check("abort_set_reg_pre", 64'(set_reg), 64'd1);
      rst = 1'b1;
      tick();
      check("abort_left",     64'(left_out), 64'd0);
      check("abort_top",      64'(top_out),  64'd0);
      check("abort_set_reg",  64'(set_reg),  64'd0);
      check("abort_busy",     64'(busy),     64'd0);
      check("abort_in_ready", 64'(in_ready), 64'd0);
      rst = 1'b0; in_valid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick();
         check("abort_no_done", 64'(done), 64'd0);
         check("abort_idle",    64'(busy), 64'd0);
      end

      // Skew: single beat, lane i appears at c+1+i.
      start = 1'b1; k_len = 5'd1;
      tick();
      start = 1'b0;
      in_valid = 1'b1; a_vec = 32'h0403_0201; b_vec = 32'h0807_0605;
      check("skew_left_c0",    64'(left_out), 64'd0);
      check("skew_set_reg_c0", 64'(set_reg),  64'd0);
      tick();
      check("skew_in_ready_c1", 64'(in_ready), 64'd0);
      for (int k = 0; k < 5; k++) begin
         check("skew_left", 64'(left_out), 64'(exp_left[k]));
         check("skew_top",  64'(top_out),  64'(exp_top[k]));
         tick();
      end
      in_valid = 1'b0;
      check("skew_set_reg_c6", 64'(set_reg), 64'd1);
      tick();
      check("skew_set_reg_c7", 64'(set_reg), 64'd1);
      tick();
      check("skew_done_c8",    64'(done),    64'd1);
      check("skew_set_reg_c8", 64'(set_reg), 64'd0);
      tick();

      // set_reg window for three back-to-back beats.
      start = 1'b1; k_len = 5'd3;
      tick();
      start = 1'b0;
      in_valid = 1'b1; a_vec = 32'h1111_1111; b_vec = 32'h2222_2222;
      check("win_set_reg_F", 64'(set_reg), 64'd0);
      tick(); tick(); tick();
      in_valid = 1'b0;
      check("win_in_ready_L1", 64'(in_ready), 64'd0);
      tail("win");

      // Bubbles: 3 idle cycles between two beats.
      start = 1'b1; k_len = 5'd2;
      tick();
      start = 1'b0;
      in_valid = 1'b1; a_vec = 32'h0000_1211; b_vec = 32'h0000_5655;
      tick();
      in_valid = 1'b0;
      check("bub_lane0_b1",   64'(left_out[7:0]), 64'h11);
      check("bub_in_ready",   64'(in_ready),      64'd1);
      for (int g = 0; g < 3; g++) begin
         tick();
         check("bub_gap_left0", 64'(left_out[7:0]), 64'h00);
         check("bub_gap_top0",  64'(top_out[7:0]),  64'h00);
         check("bub_gap_set",   64'(set_reg),       64'd1);
         check("bub_gap_busy",  64'(busy),          64'd1);
      end
      in_valid = 1'b1; a_vec = 32'h0000_0022; b_vec = 32'h0000_0066;
      tick();
      in_valid = 1'b0;
      check("bub_lane0_b2_left", 64'(left_out[7:0]), 64'h22);
      check("bub_lane0_b2_top",  64'(top_out[7:0]),  64'h66);
      tail("bub");

      // Zero-length job, then a start during DONE is ignored.
      start = 1'b1; k_len = 5'd0;
      check("zero_in_ready_s", 64'(in_ready), 64'd0);
      tick();
      k_len = 5'd3;
      check("zero_done",     64'(done),     64'd1);
      check("zero_busy",     64'(busy),     64'd0);
      check("zero_set_reg",  64'(set_reg),  64'd0);
      check("zero_in_ready", 64'(in_ready), 64'd0);
      tick();
      start = 1'b0;
      check("done_start_ign_busy",  64'(busy),     64'd0);
      check("done_start_ign_ready", 64'(in_ready), 64'd0);
      check("done_start_ign_set",   64'(set_reg),  64'd0);
      tick();
      check("done_start_ign_busy2", 64'(busy), 64'd0);

      // End-to-end: A = identity, B[k][j] = 16k+j+1, so the grid must hold B.
      pe_clr = 1'b1;
      tick();
      pe_clr = 1'b0;
      start = 1'b1; k_len = 5'd4;
      tick();
      start = 1'b0;
      for (int k = 0; k < N; k++) begin
         in_valid = 1'b1;
         a_vec = 32'd1 << (8 * k);
         for (int j = 0; j < N; j++) b_vec[j*DW +: DW] = 8'(16 * k + j + 1);
         if (k == 1) begin
            start = 1'b1; k_len = 5'd1;
         end
         if (k == 2) check("e2e_start_ignored_ready", 64'(in_ready), 64'd1);
         tick();
         start = 1'b0;
      end
      in_valid = 1'b0;
      check("e2e_in_ready_L1", 64'(in_ready), 64'd0);
      tail("e2e");
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            check($sformatf("e2e_c%0d%0d", i, j), 64'(acc[i][j]), 64'(16 * i + j + 1));
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
